// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer and architectural HI/LO registers for the E stage.
// Latency: mult/multu MULT_CYCLES, div/divu DIV_CYCLES edges from start to HI/LO update; mthi/mtlo one edge; mf reads zero latency.
// Backpressure: mdu_stall freezes D while an MDU instruction waits behind a busy or starting unit; start during RUN is ignored.
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_in_D,
    output logic        busy,
    output logic        mdu_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_result
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;
    logic        r_commit;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_arith;
    logic        w_accept;
    logic [3:0]  w_load;
    logic        w_div_zero;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [31:0] w_div_n;
    logic [31:0] w_div_d;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [63:0] w_res;

    // Ops 0..3 are the long-latency arithmetic group; bit 2 clear identifies them.
    assign w_arith    = ~mdu_op[2];
    assign w_accept   = start & (r_state == ST_IDLE);
    assign w_load     = mdu_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    assign w_div_zero = (rt_val == 32'd0);

    // Products are formed on explicitly extended 64-bit operands so the sign handling is visible.
    assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // One shared unsigned divider; signed div runs on magnitudes and fixes signs afterwards.
    // 0x80000000 keeps its own bit pattern as a magnitude, which yields the required overflow result.
    assign w_rs_mag = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    assign w_rt_mag = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
    assign w_div_n  = (mdu_op == OP_DIV) ? w_rs_mag : rs_val;
    // Divisor forced to 1 on zero so the divider never sees 0; the result is discarded anyway.
    assign w_div_d  = w_div_zero ? 32'd1 : ((mdu_op == OP_DIV) ? w_rt_mag : rt_val);
    assign w_quo    = w_div_n / w_div_d;
    assign w_rem    = w_div_n % w_div_d;
    assign w_sq     = (rs_val[31] ^ rt_val[31]) ? (~w_quo + 32'd1) : w_quo;
    assign w_sr     = rs_val[31] ? (~w_rem + 32'd1) : w_rem;

    // Select the {hi, lo} result for the operation presented in E.
    always_comb begin
        w_res = 64'd0;
        case (mdu_op)
            OP_MULT:  w_res = w_prod_s;
            OP_MULTU: w_res = w_prod_u;
            OP_DIV:   w_res = {w_sr, w_sq};
            OP_DIVU:  w_res = {w_rem, w_quo};
            default:  w_res = 64'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: IDLE enters RUN on an arithmetic start; RUN leaves on the final count.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start && w_arith) w_next_state = ST_RUN;
            ST_RUN:  if (r_cnt == 4'd1) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Counter, result latches and HI/LO updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= 4'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
            r_commit <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1 && r_commit) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end
        end else if (w_accept) begin
            if (w_arith) begin
                r_res_hi <= w_res[63:32];
                r_res_lo <= w_res[31:0];
                r_cnt    <= w_load;
                // Divide by zero still occupies the unit but leaves HI/LO untouched.
                r_commit <= ~(mdu_op[1] & w_div_zero);
            end else if (mdu_op == OP_MTHI) begin
                r_hi <= rs_val;
            end else if (mdu_op == OP_MTLO) begin
                r_lo <= rs_val;
            end
        end
    end

    // Move-from read path, zero latency from the architectural registers.
    always_comb begin
        mf_result = 32'd0;
        case (mdu_op)
            OP_MFHI: mf_result = r_hi;
            OP_MFLO: mf_result = r_lo;
            default: mf_result = 32'd0;
        endcase
    end

    assign busy      = (r_state == ST_RUN);
    assign mdu_stall = md_in_D & (busy | (start & w_arith));
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with default latencies (mult 5, div 10).
// Inputs are driven just after the falling edge and outputs are checked 1ns later.
module tb_mdu_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_in_D;
    logic        busy;
    logic        mdu_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_result;

    int total;
    int bad;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mdu_op    (mdu_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .md_in_D   (md_in_D),
        .busy      (busy),
        .mdu_stall (mdu_stall),
        .hi        (hi),
        .lo        (lo),
        .mf_result (mf_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue one mult/div in the current cycle, check every busy cycle, then the completion cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int n, input logic md,
                          input logic [31:0] nhi, input logic [31:0] nlo);
        start = 1'b1; mdu_op = op; rs_val = rs; rt_val = rt; md_in_D = md;
        #1;
        chk({tag, "_stall_start"}, 32'(mdu_stall), 32'(md));
        chk({tag, "_busy_start"}, 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            chk({tag, "_busy_run"}, 32'(busy), 32'd1);
            chk({tag, "_stall_run"}, 32'(mdu_stall), 32'(md));
            chk({tag, "_hi_run"}, hi, exp_hi);
            chk({tag, "_lo_run"}, lo, exp_lo);
        end
        @(negedge clk);
        #1;
        exp_hi = nhi;
        exp_lo = nlo;
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_stall_done"}, 32'(mdu_stall), 32'd0);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        reset = 1'b0;
        start = 1'b0;
        mdu_op = 3'd0;
        rs_val = 32'd0;
        rt_val = 32'd0;
        md_in_D = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", 32'(mdu_stall), 32'd0);
        chk("rst_mf", mf_result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;

        // Arithmetic, issued back-to-back (each starts in the first idle cycle).
        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0", 3'd3, 32'h0000_0123, 32'd0, 10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'h0000_0000, 32'h8000_0000);
        run_op("divneg", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu", 3'd3, 32'd100, 32'd7, 10, 1'b0, 32'h0000_0002, 32'h0000_000E);

        // mtlo presented during a mult run must be ignored.
        start = 1'b1; mdu_op = 3'd0; rs_val = 32'd3; rt_val = 32'd4; md_in_D = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; mdu_op = 3'd5; rs_val = 32'h0000_1234;
        #1;
        chk("ign_busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0; mdu_op = 3'd0; rs_val = 32'd3;
        #1;
        chk("ign_lo_kept", lo, exp_lo);
        repeat (3) @(negedge clk);
        #1;
        chk("ign_busy_done", 32'(busy), 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd12;
        chk("ign_hi", hi, exp_hi);
        chk("ign_lo", lo, exp_lo);

        // Same mtlo in IDLE takes effect after one edge with no busy period.
        start = 1'b1; mdu_op = 3'd5; rs_val = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        #1;
        exp_lo = 32'h0000_1234;
        chk("mtlo_lo", lo, exp_lo);
        chk("mtlo_busy", 32'(busy), 32'd0);

        // mthi then mfhi in the next cycle.
        start = 1'b1; mdu_op = 3'd4; rs_val = 32'hAAAA_5555;
        @(negedge clk);
        mdu_op = 3'd6;
        #1;
        exp_hi = 32'hAAAA_5555;
        chk("mfhi", mf_result, exp_hi);
        chk("mthi_busy", 32'(busy), 32'd0);
        mdu_op = 3'd7;
        #1;
        chk("mflo", mf_result, exp_lo);
        start = 1'b0; mdu_op = 3'd0;
        #1;
        chk("mf_none", mf_result, 32'd0);
        @(negedge clk);
        #1;
        chk("mf_hi_kept", hi, exp_hi);

        // Reset in the middle of a mult (cnt == 2) abandons it.
        start = 1'b1; mdu_op = 3'd0; rs_val = 32'd3; rt_val = 32'd4; md_in_D = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_busy_pre", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_stall", 32'(mdu_stall), 32'd0);
        chk("mid_hi", hi, exp_hi);
        chk("mid_lo", lo, exp_lo);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        run_op("post_rst", 3'd0, 32'd3, 32'd4, 5, 1'b0, 32'd0, 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide sequencer and HI/LO register file for the E stage of the five-stage MIPS pipeline. It accepts one MDU operation per cycle from E, runs multiply/divide for a fixed parameterised latency, and owns the architectural HI/LO registers. It produces `mdu_stall`, which is asserted while the decode-stage instruction uses the MDU and the unit is busy or starting. The top level ORs `mdu_stall` into the D-stage freeze.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1..15.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately when it is 0.
- `start`  in  1  E-stage instruction is an MDU operation (valid this cycle).
- `mdu_op`  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo.
- `rs_val`  in  32  forwarded rs operand in E.
- `rt_val`  in  32  forwarded rt operand in E.
- `md_in_D`  in  1  D-stage instruction is any MDU instruction (decoder stop flag).
- `busy`  out  1  a mult/div is in progress.
- `mdu_stall`  out  1  equals `md_in_D & (busy | (start & mdu_op <= 3))`.
- `hi`  out  32  architectural HI register.
- `lo`  out  32  architectural LO register.
- `mf_result`  out  32  `hi` when `mdu_op==6`, `lo` when `mdu_op==7`, otherwise 0.

## Operation
- FSM states:
  - IDLE: accepts `start`.
  - RUN: counter `cnt` is nonzero.
- Internal result latches are `res_hi` and `res_lo`.
- In IDLE with `start` and `mdu_op` 0..3:
  - Compute the result from `rs_val`/`rt_val` combinationally.
  - Capture it into `res_hi`/`res_lo`.
  - Load `cnt` with MULT_CYCLES (ops 0, 1) or DIV_CYCLES (ops 2, 3).
  - Go to RUN.
- In RUN:
  - `cnt` decrements every cycle.
  - On the edge where `cnt` goes 1→0, `hi`/`lo` take `res_hi`/`res_lo` and the state returns to IDLE.
- Arithmetic rules:
  - mult: signed 32×32→64; `hi`=[63:32], `lo`=[31:0].
  - multu: unsigned 32×32→64, same split as mult.
  - div: signed division. `lo`=quotient truncated toward zero; `hi`=remainder with the sign of the dividend (`rs_val`).
  - divu: unsigned quotient in `lo`, remainder in `hi`.
  - Division by zero (rt_val==0): unit still goes busy for DIV_CYCLES; HI/LO are left unchanged at completion.
  - div of 0x80000000 by 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- mthi/mtlo (IDLE, `start`): `hi` (or `lo`) ← `rs_val` on that edge; no busy period.
- mfhi/mflo: purely combinational read through `mf_result`; no state change.
- `start` while in RUN: ignored completely (no state change). The pipeline guarantees it never happens via `mdu_stall`.
- mthi/mtlo with `start` in RUN: ignored.
- Reset while in RUN: the operation is abandoned.
- Reset values (all on `reset`=0): state IDLE, `cnt`=0, `hi`=`lo`=0, `res_hi`=`res_lo`=0, `busy`=0.

## Timing
- `start` is sampled at edge E0.
- `busy` is 1 from just after E0 through edge E0+N, where N is MULT_CYCLES or DIV_CYCLES.
- `hi`/`lo` are updated at edge E0+N; `busy` falls at the same edge.
- An mfhi in E during the cycle after E0+N reads the new value.
- `mdu_stall` is combinational. It is already high in the cycle of the `start` itself when an MDU instruction sits in D. It stays high through the last busy cycle and is low in the cycle after E0+N.
- Back-to-back: a new `start` in the first IDLE cycle after completion is accepted. Throughput is one op per N+1 cycles.
- mthi/mtlo: `hi`/`lo` are visible one cycle after `start`; `busy` stays 0.
- `mf_result` reflects the current register values with zero latency. When mfhi is in E on the same cycle an mthi wrote at the previous edge, it sees the new value.

## Test plan
- Reset mid-run: start mult 3×4, pull `reset` low at cnt=2 → `busy`=0 and `hi`=`lo`=0 immediately; after release, state is IDLE and a new op is accepted.
- mult signed: rs=0xFFFFFFFE (-2), rt=3 → `busy` high 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. multu with the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- div signed: rs=-7 (0xFFFFFFF9), rt=2 → after 10 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. divu with rt=0 → HI/LO unchanged and `busy` still lasts 10 cycles.
- Stall window: start div, hold `md_in_D`=1 → `mdu_stall`=1 on the start cycle and all 10 busy cycles, 0 on the next cycle; with `md_in_D`=0, `mdu_stall` stays 0 throughout.
- Ignored start: during mult RUN drive `start` with op=mtlo, rs=0x1234 → `lo` is not 0x1234 and the mult completes normally. In IDLE the same stimulus → `lo`=0x1234 after one edge with `busy`=0.
- Back-to-back with read: mthi 0xAAAA5555 followed next cycle by mfhi → `mf_result`=0xAAAA5555. With `mdu_op`=0 and no start, `mf_result`=0.
